// File: rtl/kf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kf_pkg
// Purpose : Shared definitions for the Kalman-filter measurement front end.
//           Holds the default element width, vector length and FIFO depth,
//           and the state encoding of the measurement-assembly FSM.
// Revision: 1.0  initial release
// ============================================================================
package kf_pkg;

   localparam int c_kf_data_w     = 64;  // bits per measurement element
   localparam int c_kf_meas_n     = 6;   // elements per measurement vector z
   localparam int c_kf_fifo_depth = 8;   // element FIFO depth (power of 2)

   // Measurement-assembly FSM states
   typedef enum logic [1:0] {
      S_FILL  = 2'd0,   // popping elements into the assembly register
      S_READY = 2'd1,   // full vector assembled, waiting for mdi_req
      S_DONE  = 2'd2    // final vector of the sequence delivered
   } meas_state_t;

endpackage : kf_pkg
`default_nettype wire

// File: rtl/kf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : kf_sync_fifo
// Purpose : Single-clock FIFO with occupancy count. Read data is the head
//           entry presented combinationally from the storage array, so an
//           entry written on one edge is poppable on the following edge.
//           Simultaneous push and pop is legal at any level.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           wr_en/wr_data - push request and data (ignored while full)
//           rd_en/rd_data - pop request and head data (ignored while empty)
//           full, empty   - occupancy flags
//           level         - current number of stored entries
// Revision: 1.0  initial release
// ============================================================================
module kf_sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int                 c_ptr_w    = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_full_lvl = (c_ptr_w + 1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_level;
   logic               w_push;
   logic               w_pop;

   assign full    = (r_level == c_full_lvl);
   assign empty   = (r_level == '0);
   assign level   = r_level;
   assign rd_data = r_mem[r_rd_ptr];

   assign w_push  = wr_en && !full;
   assign w_pop   = rd_en && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while the count says
   // they are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule : kf_sync_fifo
`default_nettype wire

// File: rtl/kf_meas_input.sv
`default_nettype none
// ============================================================================
// Module  : kf_meas_input
// Purpose : Measurement input stage of the Kalman-filter datapath. Buffers
//           streamed elements in a FIFO, assembles them into MEAS_N-element
//           vectors and hands each vector to the controller when it asks
//           (mdi_req). Tracks the end of a measurement sequence and flags
//           framing errors (end marker on a non-final element).
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           start               - sequence start; its rising edge re-arms
//           meas_data/valid/end - element stream in, meas_ready handshake
//           mdi_req             - controller waiting for a vector
//           z_vec               - delivered vector, element k at k*DATA_W
//           MDI_Valid           - one-cycle pulse when z_vec is updated
//           End_valid           - final vector of the sequence delivered
//           err_frame           - sticky framing-error flag
//           fifo_level          - element FIFO occupancy
// Revision: 1.0  initial release
// ============================================================================
module kf_meas_input
   import kf_pkg::*;
#(
   parameter int DATA_W     = c_kf_data_w,
   parameter int MEAS_N     = c_kf_meas_n,
   parameter int FIFO_DEPTH = c_kf_fifo_depth
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [DATA_W-1:0]             meas_data,
   input  logic                          meas_valid,
   input  logic                          meas_end,
   output logic                          meas_ready,
   input  logic                          mdi_req,
   output logic [MEAS_N*DATA_W-1:0]      z_vec,
   output logic                          MDI_Valid,
   output logic                          End_valid,
   output logic                          err_frame,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int                 c_idx_w    = (MEAS_N > 1) ? $clog2(MEAS_N) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MEAS_N - 1);

   meas_state_t               r_state;
   meas_state_t               w_next_state;
   logic [c_idx_w-1:0]        r_idx;
   logic [DATA_W-1:0]         r_asm [MEAS_N];
   logic [MEAS_N*DATA_W-1:0]  w_asm_flat;
   logic                      r_end_pend;
   logic                      r_start_d;
   logic                      w_start_rise;
   logic [DATA_W:0]           w_fifo_dout;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
   logic                      w_pop;
   logic                      w_deliver;
   logic                      w_pop_last;
   logic                      w_pop_end;

   // ------------------------------------------------------------------
   // Element FIFO: each entry carries {meas_end, meas_data}
   // ------------------------------------------------------------------
   kf_sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (meas_valid),
      .wr_data ({meas_end, meas_data}),
      .rd_en   (w_pop),
      .rd_data (w_fifo_dout),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .level   (fifo_level)
   );

   assign meas_ready   = !w_fifo_full;
   assign w_start_rise = start && !r_start_d;
   assign w_pop_last   = (r_idx == c_last_idx);
   assign w_pop_end    = w_fifo_dout[DATA_W];

   for (genvar k = 0; k < MEAS_N; k++) begin : g_flat
      assign w_asm_flat[k*DATA_W +: DATA_W] = r_asm[k];
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FILL;
      else        r_state <= w_next_state;
   end

   // ------------------------------------------------------------------
   // FSM: next state, pop and delivery strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_deliver    = 1'b0;
      case (r_state)
         S_FILL: begin
            if (!w_fifo_empty) begin
               w_pop = 1'b1;
               if (w_pop_last) w_next_state = S_READY;
            end
         end
         S_READY: begin
            if (mdi_req) begin
               w_deliver    = 1'b1;
               w_next_state = r_end_pend ? S_DONE : S_FILL;
            end
         end
         S_DONE: begin
            if (w_start_rise) w_next_state = S_FILL;
         end
         default: w_next_state = S_FILL;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: assembly register, delivery and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_end_pend <= 1'b0;
         r_start_d  <= 1'b0;
         z_vec      <= '0;
         MDI_Valid  <= 1'b0;
         End_valid  <= 1'b0;
         err_frame  <= 1'b0;
         for (int k = 0; k < MEAS_N; k++) r_asm[k] <= '0;
      end else begin
         r_start_d <= start;
         MDI_Valid <= w_deliver;

         if (w_pop) begin
            r_asm[r_idx] <= w_fifo_dout[DATA_W-1:0];
            if (w_pop_last) begin
               r_idx      <= '0;
               r_end_pend <= w_pop_end;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end

         // A new sequence start re-arms the end indication. Outside the
         // done state the partially assembled vector is deliberately kept.
         if (w_start_rise) begin
            End_valid <= 1'b0;
            if (r_state == S_DONE) r_end_pend <= 1'b0;
            else                   err_frame  <= 1'b0;
         end

         // Misplaced end marker: flag it, keep the element, drop the marker.
         // Placed after the start clear so a coincident error is not lost.
         if (w_pop && !w_pop_last && w_pop_end) err_frame <= 1'b1;

         if (w_deliver) begin
            z_vec <= w_asm_flat;
            if (r_end_pend) End_valid <= 1'b1;
         end
      end
   end

endmodule : kf_meas_input
`default_nettype wire

// File: tb/tb_kf_meas_input.sv
`default_nettype none
// ============================================================================
// Module  : tb_kf_meas_input
// Purpose : Self-checking bench for kf_meas_input. A queue of accepted
//           elements is the reference: vector v is elements v*MEAS_N ..
//           v*MEAS_N+MEAS_N-1 of that stream, and the sequence end / framing
//           error status follows from the end markers in the stream.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kf_meas_input;

   localparam int DW = 64;
   localparam int MN = 6;
   localparam int FD = 8;
   localparam int LW = $clog2(FD) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [DW-1:0]    meas_data;
   logic             meas_valid;
   logic             meas_end;
   logic             meas_ready;
   logic             mdi_req;
   logic [MN*DW-1:0] z_vec;
   logic             MDI_Valid;
   logic             End_valid;
   logic             err_frame;
   logic [LW-1:0]    fifo_level;

   int               checks = 0;
   int               errors = 0;
   bit               push_done;

   logic [MN*DW-1:0] got_q [$];
   logic [DW-1:0]    stream_d [$];
   logic             stream_e [$];

   always #5 clk = ~clk;

   kf_meas_input #(.DATA_W(DW), .MEAS_N(MN), .FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .meas_data  (meas_data),
      .meas_valid (meas_valid),
      .meas_end   (meas_end),
      .meas_ready (meas_ready),
      .mdi_req    (mdi_req),
      .z_vec      (z_vec),
      .MDI_Valid  (MDI_Valid),
      .End_valid  (End_valid),
      .err_frame  (err_frame),
      .fifo_level (fifo_level)
   );

   // Capture every delivered vector
   always @(negedge clk) begin
      if (rst_n === 1'b1 && MDI_Valid === 1'b1) got_q.push_back(z_vec);
   end

   // ---------------- reference model ----------------
   function automatic logic [MN*DW-1:0] model_vec(input int v);
      logic [MN*DW-1:0] r;
      r = '0;
      for (int k = 0; k < MN; k++) r[k*DW +: DW] = stream_d[v*MN + k];
      return r;
   endfunction

   function automatic logic model_err();
      logic e;
      e = 1'b0;
      for (int i = 0; i < stream_e.size(); i++)
         if ((i % MN) != MN - 1 && stream_e[i]) e = 1'b1;
      return e;
   endfunction

   function automatic logic model_end(input int v);
      return stream_e[v*MN + MN - 1];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; meas_valid = 1'b0; meas_end = 1'b0;
      meas_data = '0; mdi_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got_q.delete(); stream_d.delete(); stream_e.delete();
      rst_n = 1'b1;
   endtask

   task automatic push_elem(input logic [DW-1:0] d, input logic e);
      int n;
      n = 0;
      meas_data = d; meas_end = e; meas_valid = 1'b1;
      @(negedge clk);
      while (meas_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (meas_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL push_timeout: meas_ready=%b want 1 within 200 cycles", meas_ready);
         meas_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      stream_d.push_back(d);
      stream_e.push_back(e);
      meas_valid = 1'b0;
   endtask

   task automatic wait_vecs(input int k, input int budget);
      int n;
      n = 0;
      while (got_q.size() < k && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (got_q.size() < k) begin
         checks++; errors++;
         $display("FAIL vec_timeout: got %0d vectors want %0d", got_q.size(), k);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; meas_valid = 1'b0; meas_end = 1'b0;
      meas_data = '0; mdi_req = 1'b0;
      #2;
      checks++; if (meas_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", meas_ready); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      checks++; if (z_vec !== '0) begin errors++; $display("FAIL reset_zvec: got %h want 0", z_vec); end
      checks++; if (MDI_Valid !== 1'b0) begin errors++; $display("FAIL reset_mdi: got %b want 0", MDI_Valid); end
      checks++; if (End_valid !== 1'b0) begin errors++; $display("FAIL reset_end: got %b want 0", End_valid); end
      checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_frame); end
   endtask

   task automatic test_single_vector();
      do_reset();
      mdi_req = 1'b1;
      for (int i = 1; i <= MN; i++) push_elem(DW'(i), 1'b0);
      wait_vecs(1, 50);
      idle(10);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== model_vec(0)) begin errors++; $display("FAIL single_vec: got %h want %h", got_q[0], model_vec(0)); end
      end
      checks++; if (z_vec !== model_vec(0)) begin errors++; $display("FAIL single_hold: got %h want %h", z_vec, model_vec(0)); end
      checks++; if (End_valid !== 1'b0) begin errors++; $display("FAIL single_end: got %b want 0", End_valid); end
   endtask

   task automatic test_sequence_end();
      do_reset();
      for (int v = 0; v < 2; v++) begin
         mdi_req = 1'b0;
         for (int k = 0; k < MN; k++) push_elem(DW'(v*MN + k + 1), (v == 1 && k == MN - 1));
         idle(3);
         checks++; if (got_q.size() !== v) begin errors++; $display("FAIL seq_no_req: got %0d vectors want %0d", got_q.size(), v); end
         mdi_req = 1'b1;
         wait_vecs(v + 1, 30);
         mdi_req = 1'b0;
         idle(2);
         if (got_q.size() > v) begin
            checks++; if (got_q[v] !== model_vec(v)) begin errors++; $display("FAIL seq_vec%0d: got %h want %h", v, got_q[v], model_vec(v)); end
         end
         checks++; if (End_valid !== model_end(v)) begin errors++; $display("FAIL seq_end%0d: got %b want %b", v, End_valid, model_end(v)); end
      end
      idle(10);
      checks++; if (End_valid !== 1'b1) begin errors++; $display("FAIL seq_end_held: got %b want 1", End_valid); end
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL seq_count: got %0d want 2", got_q.size()); end
      start = 1'b1; idle(1); start = 1'b0; idle(1);
      checks++; if (End_valid !== 1'b0) begin errors++; $display("FAIL seq_start_clear: got %b want 0", End_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      mdi_req = 1'b0;
      for (int i = 0; i < MN + FD; i++) push_elem(DW'(100 + i), 1'b0);
      idle(2);
      checks++; if (fifo_level !== LW'(FD)) begin errors++; $display("FAIL bp_level_full: got %0d want %0d", fifo_level, FD); end
      checks++; if (meas_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", meas_ready); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bp_no_req: got %0d vectors want 0", got_q.size()); end
      mdi_req = 1'b1;
      wait_vecs(1, 20);
      idle(2);
      checks++; if (meas_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", meas_ready); end
      wait_vecs(2, 30);
      idle(5);
      for (int v = 0; v < 2; v++) begin
         if (got_q.size() > v) begin
            checks++; if (got_q[v] !== model_vec(v)) begin errors++; $display("FAIL bp_vec%0d: got %h want %h", v, got_q[v], model_vec(v)); end
         end
      end
      // the two leftovers move into the assembly register
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL bp_level_drain: got %0d want 0", fifo_level); end
      mdi_req = 1'b0;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      mdi_req = 1'b0;
      for (int i = 0; i < MN + FD; i++) push_elem(DW'(200 + i), 1'b0);
      idle(2);
      meas_data = 64'hDEAD; meas_end = 1'b0; meas_valid = 1'b1; mdi_req = 1'b1;
      @(negedge clk);
      checks++; if (meas_ready !== 1'b0) begin errors++; $display("FAIL fpp_ready: got %b want 0", meas_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (fifo_level !== LW'(FD)) begin errors++; $display("FAIL fpp_level8: got %0d want %0d", fifo_level, FD); end
      @(posedge clk);
      #1;
      meas_valid = 1'b0;
      @(negedge clk);
      checks++; if (fifo_level !== LW'(FD - 1)) begin errors++; $display("FAIL fpp_level7: got %0d want %0d", fifo_level, FD - 1); end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push_elem(DW'(300 + i), 1'b0);
      wait_vecs(3, 60);
      idle(3);
      if (got_q.size() >= 3) begin
         checks++; if (got_q[2] !== model_vec(2)) begin errors++; $display("FAIL fpp_vec2: got %h want %h", got_q[2], model_vec(2)); end
      end
      mdi_req = 1'b0;
   endtask

   task automatic test_frame_error();
      do_reset();
      mdi_req = 1'b1;
      for (int k = 0; k < MN; k++) push_elem(DW'(400 + k), (k == 2));
      wait_vecs(1, 40);
      idle(2);
      checks++; if (err_frame !== model_err()) begin errors++; $display("FAIL fe_err: got %b want %b", err_frame, model_err()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== model_vec(0)) begin errors++; $display("FAIL fe_vec: got %h want %h", got_q[0], model_vec(0)); end
      end
      checks++; if (End_valid !== 1'b0) begin errors++; $display("FAIL fe_end: got %b want 0", End_valid); end
      for (int k = 0; k < MN; k++) push_elem(DW'(410 + k), 1'b0);
      wait_vecs(2, 40);
      idle(2);
      checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL fe_sticky: got %b want 1", err_frame); end
      // start mid-vector clears the error but keeps the partial vector
      mdi_req = 1'b0;
      for (int k = 0; k < 3; k++) push_elem(DW'(420 + k), 1'b0);
      idle(2);
      start = 1'b1; idle(1); start = 1'b0; idle(1);
      checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL fe_start_clear: got %b want 0", err_frame); end
      for (int k = 3; k < MN; k++) push_elem(DW'(420 + k), 1'b0);
      mdi_req = 1'b1;
      wait_vecs(3, 40);
      idle(2);
      if (got_q.size() >= 3) begin
         checks++; if (got_q[2] !== model_vec(2)) begin errors++; $display("FAIL fe_partial_kept: got %h want %h", got_q[2], model_vec(2)); end
      end
      mdi_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mdi_req = 1'b1;
      for (int k = 0; k < MN; k++) push_elem(DW'(500 + k), 1'b0);
      wait_vecs(1, 40);
      idle(2);
      mdi_req = 1'b0;
      for (int k = 0; k < 3; k++) push_elem(DW'(510 + k), 1'b0);
      push_elem(DW'(513), 1'b1);
      rst_n = 1'b0;
      #1;
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
      checks++; if (meas_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", meas_ready); end
      checks++; if (z_vec !== '0) begin errors++; $display("FAIL rm_zvec: got %h want 0", z_vec); end
      checks++; if (End_valid !== 1'b0 || err_frame !== 1'b0 || MDI_Valid !== 1'b0) begin
         errors++; $display("FAIL rm_flags: got end=%b err=%b mdi=%b want 0 0 0", End_valid, err_frame, MDI_Valid);
      end
      @(posedge clk);
      #1;
      got_q.delete(); stream_d.delete(); stream_e.delete();
      rst_n = 1'b1;
      mdi_req = 1'b1;
      for (int k = 0; k < MN; k++) push_elem(DW'(600 + k), 1'b0);
      wait_vecs(1, 40);
      idle(10);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rm_count: got %0d want 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== model_vec(0)) begin errors++; $display("FAIL rm_vec: got %h want %h", got_q[0], model_vec(0)); end
      end
      mdi_req = 1'b0;
   endtask

   task automatic test_random();
      int nv;
      bit fin;
      for (int r = 0; r < 6; r++) begin
         do_reset();
         nv  = int'($urandom_range(1, 4));
         fin = 1'($urandom_range(0, 1));
         push_done = 1'b0;
         fork
            begin
               for (int i = 0; i < nv*MN; i++) begin
                  idle(int'($urandom_range(0, 2)));
                  push_elem({$urandom, $urandom}, fin && (i == nv*MN - 1));
               end
               push_done = 1'b1;
            end
            begin
               while (!push_done) begin
                  @(posedge clk);
                  #1;
                  mdi_req = ($urandom_range(0, 2) != 0);
               end
            end
         join
         mdi_req = 1'b1;
         wait_vecs(nv, 200);
         idle(4);
         mdi_req = 1'b0;
         checks++; if (got_q.size() !== nv) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_q.size(), nv); end
         for (int v = 0; v < nv; v++) begin
            if (v < got_q.size()) begin
               checks++; if (got_q[v] !== model_vec(v)) begin errors++; $display("FAIL rnd%0d_vec%0d: got %h want %h", r, v, got_q[v], model_vec(v)); end
            end
         end
         checks++; if (End_valid !== model_end(nv - 1)) begin errors++; $display("FAIL rnd%0d_end: got %b want %b", r, End_valid, model_end(nv - 1)); end
         checks++; if (err_frame !== model_err()) begin errors++; $display("FAIL rnd%0d_err: got %b want %b", r, err_frame, model_err()); end
         if (fin) begin
            start = 1'b1; idle(1); start = 1'b0; idle(1);
            checks++; if (End_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_start: got %b want 0", r, End_valid); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_vector();
      test_sequence_end();
      test_backpressure();
      test_full_push_pop();
      test_frame_error();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_kf_meas_input
`default_nettype wire

// File: doc/kf_meas_input.md
KF_MEAS_INPUT -- requirements
Module: kf_meas_input

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of one measurement element.
REQ-002 SHALL have parameter MEAS_N, default 6, elements per measurement vector z.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=2), element FIFO depth.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  sequence start, same signal the KF controller receives; rising edge clears End_valid and the done state.
REQ-007 meas_data  in  DATA_W  measurement element.
REQ-008 meas_valid  in  1  element valid.
REQ-009 meas_end  in  1  marks the last element of the final vector of a sequence.
REQ-010 meas_ready  out  1  element accepted when meas_valid && meas_ready.
REQ-011 mdi_req  in  1  level, downstream controller waiting in its measurement-input phase.
REQ-012 z_vec  out  MEAS_N*DATA_W  delivered vector, element k at bits [k*DATA_W +: DATA_W].
REQ-013 MDI_Valid  out  1  one-cycle pulse, z_vec updated this cycle.
REQ-014 End_valid  out  1  level, final vector of sequence delivered.
REQ-015 err_frame  out  1  sticky, meas_end on a non-final element index.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Push on meas_valid && meas_ready; meas_ready SHALL equal !fifo_full, so a push while full never occurs.
REQ-018 FIFO entry SHALL store {meas_end, meas_data}; push and pop in the same cycle SHALL be legal at any level, occupancy unchanged.
REQ-019 FSM states: S_FILL, S_READY, S_DONE.
REQ-020 S_FILL: when FIFO is non-empty, pop one element per cycle into assembly register asm[idx]; idx++.
REQ-021 Earliest pop of an element pushed at cycle t SHALL be cycle t+1.
REQ-022 Popping idx==MEAS_N-1 SHALL latch end_pend=popped meas_end, reset idx to 0, go to S_READY.
REQ-023 Popping idx<MEAS_N-1 with meas_end=1 SHALL set err_frame; the flag bit is discarded and the element is kept.
REQ-024 S_READY: no pops; when mdi_req=1, the next cycle SHALL pulse MDI_Valid for exactly one cycle and load z_vec<=asm in that same edge.
REQ-025 On that delivery: if end_pend=1, set End_valid and go to S_DONE; else go to S_FILL.
REQ-026 z_vec SHALL hold its value between deliveries; assembling the next vector SHALL NOT disturb it.
REQ-027 S_DONE: no pops, FIFO continues accepting; start rising edge (start && !start_d) SHALL clear End_valid and end_pend and go to S_FILL.
REQ-028 start rising edge in S_FILL/S_READY SHALL clear End_valid and err_frame only; the partial vector is kept.
REQ-029 mdi_req held high across multiple vectors SHALL give one MDI_Valid per completed vector, never back-to-back for the same vector.

Reset
REQ-030 rst_n low SHALL immediately force: state S_FILL, idx 0, FIFO empty, fifo_level 0, meas_ready 1, z_vec 0, asm 0, MDI_Valid 0, End_valid 0, err_frame 0, end_pend 0, start_d 0.
REQ-031 Reset mid-vector or mid-FIFO SHALL discard all buffered data; no MDI_Valid SHALL follow for it.

Structure
REQ-032 Shared package kf_pkg SHALL hold DATA_W/MEAS_N defaults and the meas FSM state enum.
REQ-033 FIFO SHALL be a sub-module kf_sync_fifo (width DATA_W+1, depth FIFO_DEPTH, full/empty/level outputs, async active-low reset).

Verification
REQ-034 Push 6 elements 1..6 (last meas_end=0), mdi_req=1 -> single MDI_Valid, z_vec elements 0..5 = 1..6, End_valid=0.
REQ-035 Push 12 elements with element 12 meas_end=1, mdi_req toggled per vector -> 2 MDI_Valid pulses, End_valid=1 after the second and held; start pulse -> End_valid=0.
REQ-036 mdi_req=0, push 14 elements -> 6 into asm, fifo_level=8, meas_ready=0; mdi_req=1 -> delivery, FIFO drains, meas_ready=1 next cycle.
REQ-037 meas_end=1 on element index 2 -> err_frame=1 sticky, vector still delivered with 6 elements, End_valid=0.
REQ-038 rst_n low after 3 of 6 elements -> all outputs zero; 6 fresh elements yield exactly one MDI_Valid with only the fresh data.
REQ-039 Simultaneous push and pop at fifo_level=8 with meas_ready=0 -> no push accepted, level 7 next cycle.
